// File: rtl/instruction_cache_if.sv
// Instruction cache bus: program-counter fetch port plus DDR burst-read port.
// The PC/DDR side drives "master"; the cache attaches as "slave".
interface instruction_cache_if #(
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int ISA_WIDTH      = 64
);
  logic [ADDR_WIDTH_MEM-1:0] addr_ins;
  logic                      ins_cache_rdy;
  logic [3:0]                st_cur_ins_cache;
  logic [9:0]                load_times;
  logic [ISA_WIDTH-1:0]      ins_out;
  logic                      ins_out_valid;
  logic                      ddr_rd_req;
  logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr;
  logic [9:0]                ddr_rd_len;
  logic                      ddr_rd_ack;
  logic                      ddr_rd_valid;
  logic [ISA_WIDTH-1:0]      ddr_rd_data;

  modport slave (
    input  addr_ins,
    input  ddr_rd_ack,
    input  ddr_rd_valid,
    input  ddr_rd_data,
    output ins_cache_rdy,
    output st_cur_ins_cache,
    output load_times,
    output ins_out,
    output ins_out_valid,
    output ddr_rd_req,
    output ddr_rd_addr,
    output ddr_rd_len
  );

  modport master (
    output addr_ins,
    output ddr_rd_ack,
    output ddr_rd_valid,
    output ddr_rd_data,
    input  ins_cache_rdy,
    input  st_cur_ins_cache,
    input  load_times,
    input  ins_out,
    input  ins_out_valid,
    input  ddr_rd_req,
    input  ddr_rd_addr,
    input  ddr_rd_len
  );
endinterface

// File: rtl/instruction_cache.sv
// Single-block instruction cache: burst-fills one ISA_DEPTH block from DDR
// and serves it to the PC, refilling on any in-program miss.
module instruction_cache #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int ISA_WIDTH       = 64,
  parameter int ISA_BASE_ADDR   = 0
) (
  input logic clk,
  input logic rst,
  instruction_cache_if.slave bus_io
);

  localparam int AW    = ADDR_WIDTH_MEM;
  localparam int DW    = DDR_ADDR_WIDTH;
  localparam int OFF_W = $clog2(ISA_DEPTH);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD_REQ  = 4'd1;
  localparam logic [3:0] ST_LOAD_DATA = 4'd2;
  localparam logic [3:0] ST_SENT      = 4'd3;

  localparam logic [AW:0] TOTAL_L = (AW+1)'(TOTAL_ISA_DEPTH);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(ISA_DEPTH - 1);

  logic [3:0]           state_q, state_d;
  logic [9:0]           blk_q, blk_d;
  logic [9:0]           lt_q, lt_d;
  logic [OFF_W-1:0]     cnt_q, cnt_d;
  logic [ISA_WIDTH-1:0] ins_q, ins_d;
  logic                 vld_q, vld_d;
  logic [DW-1:0]        addr_q, addr_d;

  logic [ISA_WIDTH-1:0] mem_q [ISA_DEPTH];

  logic [AW-1:0]    a;
  logic [AW-1:0]    a_blk;
  logic [OFF_W-1:0] a_off;
  logic             a_ok;
  logic             hit;
  logic             miss;
  logic             wr_en;

  function automatic logic [DW-1:0] blk_addr(input logic [9:0] b);
    return DW'(ISA_BASE_ADDR) + (DW'(b) << (OFF_W + 3));
  endfunction

  assign a     = bus_io.addr_ins;
  assign a_blk = a >> OFF_W;
  assign a_off = a[OFF_W-1:0];
  // MSB set marks a pending jump; beyond TOTAL is program end
  assign a_ok  = !a[AW-1] && ({1'b0, a} < TOTAL_L);
  assign hit   = a_ok && (a_blk == (AW'(lt_q) - AW'(1)));
  assign miss  = a_ok && !hit;
  assign wr_en = (state_q == ST_LOAD_DATA) && bus_io.ddr_rd_valid;

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    lt_d    = lt_q;
    cnt_d   = cnt_q;
    ins_d   = ins_q;
    vld_d   = 1'b0;
    addr_d  = addr_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        blk_d   = '0;
        addr_d  = blk_addr('0);
        state_d = ST_LOAD_REQ;
      end
      (state_q == ST_LOAD_REQ): begin
        if (bus_io.ddr_rd_ack) begin
          cnt_d   = '0;
          state_d = ST_LOAD_DATA;
        end
      end
      (state_q == ST_LOAD_DATA): begin
        if (bus_io.ddr_rd_valid) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_BEAT) begin
            lt_d    = blk_q + 10'd1;
            state_d = ST_SENT;
          end
        end
      end
      (state_q == ST_SENT): begin
        if (hit) begin
          ins_d = mem_q[a_off];
          vld_d = 1'b1;
        end else if (miss) begin
          blk_d   = 10'(a_blk);
          addr_d  = blk_addr(10'(a_blk));
          state_d = ST_LOAD_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      lt_q    <= '0;
      cnt_q   <= '0;
      ins_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      lt_q    <= lt_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
    end
  end

  // Storage needs no reset; writes only happen in LOAD_DATA
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[cnt_q] <= bus_io.ddr_rd_data;
    end
  end

  assign bus_io.st_cur_ins_cache = state_q;
  assign bus_io.ins_cache_rdy    = (state_q == ST_SENT);
  assign bus_io.ddr_rd_req       = (state_q == ST_LOAD_REQ);
  assign bus_io.ddr_rd_addr      = addr_q;
  assign bus_io.ddr_rd_len       = 10'(ISA_DEPTH);
  assign bus_io.load_times       = lt_q;
  assign bus_io.ins_out          = ins_q;
  assign bus_io.ins_out_valid    = vld_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a block-level reference model
// checked every cycle, plus literal spot checks.
module tb_instruction_cache;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instruction_cache_if #(
    .ADDR_WIDTH_MEM(16), .DDR_ADDR_WIDTH(28), .ISA_WIDTH(64)
  ) bus ();

  instruction_cache #(
    .ADDR_WIDTH_MEM(16), .ISA_DEPTH(64), .TOTAL_ISA_DEPTH(128),
    .DDR_ADDR_WIDTH(28), .ISA_WIDTH(64), .ISA_BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Program image in DDR: instruction at address a of block b is b*100+100+k
  function automatic logic [63:0] word(input int a);
    return 64'((a / 64) * 100 + 100 + (a % 64));
  endfunction

  bit          m_serving = 0;
  int          m_lt      = 0;
  bit          exp_valid = 0;
  logic [63:0] exp_ins   = '0;
  bit          fill_flag = 0;
  int          fill_blk  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_serving = 0;
      m_lt      = 0;
      exp_valid = 0;
      exp_ins   = '0;
    end else begin
      int a;
      a = int'(bus.addr_ins);
      exp_valid = 0;
      if (m_serving) begin
        if (a >= 32768 || a >= 128) begin
          exp_valid = 0;
        end else if (a / 64 == m_lt - 1) begin
          exp_valid = 1;
          exp_ins   = word(a);
        end else begin
          m_serving = 0;
        end
      end
      if (fill_flag) begin
        fill_flag = 0;
        m_serving = 1;
        m_lt      = fill_blk + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("rdy", 64'(bus.ins_cache_rdy), 64'(m_serving));
    chk("st_sent", 64'(bus.st_cur_ins_cache == 4'd3), 64'(m_serving));
    chk("valid", 64'(bus.ins_out_valid), 64'(exp_valid));
    chk("ins_out", bus.ins_out, exp_ins);
    chk("load_times", 64'(bus.load_times), 64'(m_lt));
    chk("len", 64'(bus.ddr_rd_len), 64'd64);
  end

  // DDR responder: wait for request, ack after 2 cycles, stream beats.
  // abort_after > 0 stops after that many beats with valid still high.
  task automatic do_fill(input int blk, input int abort_after);
    bit seen;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (bus.ddr_rd_req) seen = 1;
    end
    chk("req_seen", 64'(seen), 64'd1);
    chk("req_addr", 64'(bus.ddr_rd_addr), 64'(blk * 512));
    @(negedge clk);
    @(negedge clk);
    bus.ddr_rd_ack = 1'b1;
    @(negedge clk);
    bus.ddr_rd_ack = 1'b0;
    chk("req_dropped", 64'(bus.ddr_rd_req), 64'd0);
    for (int k = 0; k < 64; k++) begin
      if (abort_after > 0 && k == abort_after) return;
      bus.ddr_rd_valid = 1'b1;
      bus.ddr_rd_data  = word(blk * 64 + k);
      if (k == 63) begin
        fill_blk  = blk;
        fill_flag = 1;
      end
      @(negedge clk);
    end
    bus.ddr_rd_valid = 1'b0;
  endtask

  initial begin
    bus.addr_ins     = '0;
    bus.ddr_rd_ack   = 1'b0;
    bus.ddr_rd_valid = 1'b0;
    bus.ddr_rd_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_st", 64'(bus.st_cur_ins_cache), 64'd0);
    chk("rst_req", 64'(bus.ddr_rd_req), 64'd0);
    chk("rst_addr", 64'(bus.ddr_rd_addr), 64'd0);
    rst = 1'b1;

    do_fill(0, 0);
    chk("lt1", 64'(bus.load_times), 64'd1);
    chk("st3", 64'(bus.st_cur_ins_cache), 64'd3);
    chk("rdy1", 64'(bus.ins_cache_rdy), 64'd1);

    bus.addr_ins = 16'd5;
    @(negedge clk);
    chk("ins5", bus.ins_out, 64'd105);
    chk("vld5", 64'(bus.ins_out_valid), 64'd1);
    bus.addr_ins = 16'd63;
    @(negedge clk);
    chk("ins63", bus.ins_out, 64'd163);

    bus.addr_ins = 16'd64;
    @(negedge clk);
    chk("miss_st", 64'(bus.st_cur_ins_cache), 64'd1);
    chk("miss_rdy", 64'(bus.ins_cache_rdy), 64'd0);
    chk("miss_vld", 64'(bus.ins_out_valid), 64'd0);
    chk("miss_addr", 64'(bus.ddr_rd_addr), 64'd512);
    do_fill(1, 0);
    @(negedge clk);
    chk("ins64", bus.ins_out, 64'd200);
    chk("lt2", 64'(bus.load_times), 64'd2);

    bus.addr_ins = 16'h8000;
    repeat (5) begin
      @(negedge clk);
      chk("jmp_req", 64'(bus.ddr_rd_req), 64'd0);
      chk("jmp_vld", 64'(bus.ins_out_valid), 64'd0);
      chk("jmp_st", 64'(bus.st_cur_ins_cache), 64'd3);
    end
    bus.addr_ins = 16'd3;
    do_fill(0, 0);
    @(negedge clk);
    chk("ins3", bus.ins_out, 64'd103);
    chk("lt_back", 64'(bus.load_times), 64'd1);

    bus.addr_ins = 16'd128;
    repeat (4) begin
      @(negedge clk);
      chk("end_req", 64'(bus.ddr_rd_req), 64'd0);
      chk("end_vld", 64'(bus.ins_out_valid), 64'd0);
      chk("end_st", 64'(bus.st_cur_ins_cache), 64'd3);
      chk("end_lt", 64'(bus.load_times), 64'd1);
    end

    bus.addr_ins = 16'd64;
    do_fill(1, 10);
    #2 rst = 1'b0;
    bus.ddr_rd_data = 64'd999;
    repeat (3) begin
      @(negedge clk);
      chk("ar_st", 64'(bus.st_cur_ins_cache), 64'd0);
      chk("ar_lt", 64'(bus.load_times), 64'd0);
      chk("ar_ins", bus.ins_out, 64'd0);
      chk("ar_req", 64'(bus.ddr_rd_req), 64'd0);
      chk("ar_addr", 64'(bus.ddr_rd_addr), 64'd0);
    end
    bus.ddr_rd_valid = 1'b0;
    bus.addr_ins     = 16'd2;
    rst = 1'b1;
    do_fill(0, 0);
    @(negedge clk);
    chk("ins2", bus.ins_out, 64'd102);
    chk("lt_rst", 64'(bus.load_times), 64'd1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Responder to the program counter's instruction-address interface.
- Holds one block of ISA_DEPTH instructions, fetched from DDR by burst read. Serves instructions at addr_ins to AP_ctrl.
- Reports its state and the count of loaded blocks (load_times) so the PC stalls at block boundaries.
- Refills automatically on a miss: sequential block crossing or jump target.

Parameters:
- ADDR_WIDTH_MEM, 16, instruction address width; MSB set means "address invalid / jump pending".
- ISA_DEPTH, 64, instructions per block; power of two.
- TOTAL_ISA_DEPTH, 128, program length in instructions; a multiple of ISA_DEPTH, at most 1023*ISA_DEPTH.
- DDR_ADDR_WIDTH, 28, DDR byte-address width.
- ISA_WIDTH, 64, instruction and DDR beat width (8 bytes per instruction).
- ISA_BASE_ADDR, 0, DDR byte address of instruction 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- addr_ins  in  ADDR_WIDTH_MEM  instruction address from program counter
- ins_cache_rdy  out  1  cache holds a valid block and is serving
- st_cur_ins_cache  out  4  current state register
- load_times  out  10  (index of resident block)+1; 0 means nothing loaded
- ins_out  out  ISA_WIDTH  instruction at addr_ins
- ins_out_valid  out  1  ins_out is valid for the previous cycle's addr_ins
- ddr_rd_req  out  1  burst read request, held until ack
- ddr_rd_addr  out  DDR_ADDR_WIDTH  burst start byte address
- ddr_rd_len  out  10  burst length in beats (= ISA_DEPTH)
- ddr_rd_ack  in  1  request accepted
- ddr_rd_valid  in  1  data beat valid
- ddr_rd_data  in  ISA_WIDTH  data beat

Behaviour:
- Reset values (async):
  - state = ST_IDLE; load_times = 0; blk = 0.
  - ins_cache_rdy = 0; ins_out = 0; ins_out_valid = 0.
  - ddr_rd_req = 0; ddr_rd_addr = 0; ddr_rd_len = ISA_DEPTH; beat counter = 0.
  - Buffer contents: don't-care.
- States (encoding fixed, st_cur_ins_cache = state):
  - ST_IDLE = 0: blk <= 0; next is ST_LOAD_REQ.
  - ST_LOAD_REQ = 1:
    - ddr_rd_req = 1, ddr_rd_addr = ISA_BASE_ADDR + blk*ISA_DEPTH*8.
    - On ddr_rd_ack: drop req (same edge), clear beat counter, go to ST_LOAD_DATA.
  - ST_LOAD_DATA = 2:
    - Each ddr_rd_valid writes buf[cnt] <= ddr_rd_data, cnt++.
    - On the ISA_DEPTH-th beat: load_times <= blk+1, go to ST_SENT.
  - ST_SENT = 3:
    - ins_cache_rdy = 1 (combinational from state; deasserts the first cycle the state is not SENT).
    - Each cycle, let a = addr_ins.
    - Hit: MSB(a)=0, a < TOTAL_ISA_DEPTH, and a/ISA_DEPTH == load_times-1.
      - Next edge: ins_out <= buf[a mod ISA_DEPTH], ins_out_valid <= 1. Latency 1 cycle.
    - Miss: MSB(a)=0, a < TOTAL_ISA_DEPTH, not hit.
      - blk <= a/ISA_DEPTH, ins_out_valid <= 0, go to ST_LOAD_REQ.
      - Covers the sequential boundary a == ISA_DEPTH*load_times and any jump target.
    - MSB(a)=1 (jump pending): ins_out_valid <= 0, ins_out holds, no refill, stay.
    - a >= TOTAL_ISA_DEPTH with MSB 0 (program end): ins_out_valid <= 0, no refill, stay.
- During ST_LOAD_*: ins_out_valid = 0; addr_ins is ignored until the refill completes.
- ddr_rd_valid outside ST_LOAD_DATA: ignored, no buffer write.
- ddr_rd_ack outside ST_LOAD_REQ: ignored.
- Refill of the block already resident: unreachable by definition of hit.
- load_times may decrease on a backward jump; it is set to the resident block index +1, not a cumulative count.
- Arithmetic:
  - Block index and offset are shifts/masks of addr_ins (log2 ISA_DEPTH).
  - ddr_rd_addr is computed at full DDR_ADDR_WIDTH, zero-extended, no overflow checking.
- Reset mid-burst: immediate return to ST_IDLE with all outputs at reset values. After release, block 0 is re-requested; the DDR side shares rst.

Test Plan:
- Release reset, ack after 2 cycles, 64 beats data=k+100:
  - ddr_rd_req=1 with addr=0, len=64.
  - After the last beat: load_times=1, st=3, rdy=1.
- In ST_SENT, addr_ins=5: next cycle ins_out=105, ins_out_valid=1. Then addr_ins=63: ins_out=163.
- addr_ins=64:
  - st=1, rdy=0, valid=0, ddr_rd_addr=512.
  - After 64 beats data=k+200: load_times=2, ins_out=200 one cycle after SENT.
- addr_ins=0x8000 for 5 cycles: valid=0, no ddr_rd_req, st=3. Then addr_ins=3: refill at addr 0, load_times=1, ins_out=103.
- addr_ins=128: ins_out_valid=0, no request, st stays 3, load_times unchanged.
- Assert rst after 10 beats of a refill:
  - All outputs at reset values; beats received during reset are not written.
  - After release: new request at addr 0; normal fill completes with load_times=1.
